gx4000_asic_page_mapper: RTL and testbench

Upstream feeder for the ACID/ASIC RAM block in the GX4000/Plus path. It decodes Gate Array RMR2 writes to decide when the 16 KB ASIC register page is mapped at &4000–&7FFF. While the page is mapped, it turns Z80 memory cycles in that window into single-cycle strobes on the ACID external RAM port (`asic_ram_*`), then captures the returned read data for the CPU mux.

---
 rtl/gx4000_asic_page_mapper.sv | 143 ++++++++++++++
 tb/tb_gx4000_asic_page_mapper.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx4000_asic_page_mapper.sv
// ASIC register page mapper: tracks RMR2, maps the 16 KB ASIC page at &4000-&7FFF
// and turns Z80 accesses in that window into single-cycle ACID RAM strobes.
module gx4000_asic_page_mapper #(
  parameter logic [13:0] SPR_NIBBLE_END = 14'h0FFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        plus_mode,
  input  logic        asic_unlocked,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_io_wr,
  input  logic        cpu_mem_rd,
  input  logic        cpu_mem_wr,
  input  logic [7:0]  asic_ram_q,
  output logic [13:0] asic_ram_addr,
  output logic        asic_ram_rd,
  output logic        asic_ram_wr,
  output logic [7:0]  asic_ram_din,
  output logic [4:0]  rmr2,
  output logic [1:0]  lower_rom_sel,
  output logic [2:0]  cart_bank,
  output logic        asic_page_en,
  output logic        asic_sel,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_ISSUE = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_WR_ISSUE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        io_wr_q, mem_rd_q, mem_wr_q;
  logic [4:0]  rmr2_q, rmr2_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        valid_q, valid_d;

  logic io_wr_rise, mem_rd_rise, mem_wr_rise, in_window, rmr2_cmd;

  assign io_wr_rise  = cpu_io_wr  & ~io_wr_q;
  assign mem_rd_rise = cpu_mem_rd & ~mem_rd_q;
  assign mem_wr_rise = cpu_mem_wr & ~mem_wr_q;
  assign in_window   = (cpu_addr[15:14] == 2'b01);
  assign rmr2_cmd    = io_wr_rise & in_window & (cpu_dout[7:5] == 3'b101) & asic_unlocked;

  assign asic_page_en = plus_mode & asic_unlocked & (rmr2_q[4:3] == 2'b11);
  assign asic_sel     = asic_page_en & in_window & (cpu_mem_rd | cpu_mem_wr);

  // Leaving Plus mode wipes the RMR2 state; losing unlock only hides the page.
  always_comb begin
    rmr2_d = rmr2_q;
    if (!plus_mode) begin
      rmr2_d = 5'd0;
    end else if (rmr2_cmd) begin
      rmr2_d = cpu_dout[4:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rdata_d     = rdata_q;
    valid_d     = 1'b0;
    asic_ram_rd = 1'b0;
    asic_ram_wr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (asic_page_en && in_window) begin
          if (mem_wr_rise) begin
            state_d = S_WR_ISSUE;
            addr_d  = cpu_addr[13:0];
            din_d   = (cpu_addr[13:0] <= SPR_NIBBLE_END) ? {4'h0, cpu_dout[3:0]} : cpu_dout;
          end else if (mem_rd_rise) begin
            state_d = S_RD_ISSUE;
            addr_d  = cpu_addr[13:0];
          end
        end
      end
      S_RD_ISSUE: begin
        if (plus_mode) begin
          asic_ram_rd = 1'b1;
          state_d     = S_RD_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        state_d = S_IDLE;
        if (plus_mode) begin
          rdata_d = asic_ram_q;
          valid_d = 1'b1;
        end
      end
      S_WR_ISSUE: begin
        state_d     = S_IDLE;
        asic_ram_wr = plus_mode;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      io_wr_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      rmr2_q   <= 5'd0;
      addr_q   <= 14'd0;
      din_q    <= 8'd0;
      rdata_q  <= 8'hFF;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      io_wr_q  <= cpu_io_wr;
      mem_rd_q <= cpu_mem_rd;
      mem_wr_q <= cpu_mem_wr;
      rmr2_q   <= rmr2_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
    end
  end

  assign asic_ram_addr   = addr_q;
  assign asic_ram_din    = din_q;
  assign rmr2            = rmr2_q;
  assign lower_rom_sel   = rmr2_q[4:3];
  assign cart_bank       = rmr2_q[2:0];
  assign cpu_rdata       = rdata_q;
  assign cpu_rdata_valid = valid_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_gx4000_asic_page_mapper.sv
// Bench for the ASIC page mapper: transaction-timeline model, ACID RAM model,
// per-cycle comparison plus directed literal checks.
module tb_gx4000_asic_page_mapper;

  logic        clk_sys, reset_n, plus_mode, asic_unlocked;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_io_wr, cpu_mem_rd, cpu_mem_wr;
  logic [7:0]  asic_ram_q;
  logic [13:0] asic_ram_addr;
  logic        asic_ram_rd, asic_ram_wr;
  logic [7:0]  asic_ram_din;
  logic [4:0]  rmr2;
  logic [1:0]  lower_rom_sel;
  logic [2:0]  cart_bank;
  logic        asic_page_en, asic_sel;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_valid, busy;

  gx4000_asic_page_mapper dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
    .asic_unlocked(asic_unlocked), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_io_wr(cpu_io_wr), .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr),
    .asic_ram_q(asic_ram_q), .asic_ram_addr(asic_ram_addr),
    .asic_ram_rd(asic_ram_rd), .asic_ram_wr(asic_ram_wr),
    .asic_ram_din(asic_ram_din), .rmr2(rmr2), .lower_rom_sel(lower_rom_sel),
    .cart_bank(cart_bank), .asic_page_en(asic_page_en), .asic_sel(asic_sel),
    .cpu_rdata(cpu_rdata), .cpu_rdata_valid(cpu_rdata_valid), .busy(busy)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  function automatic logic [7:0] pat(input logic [13:0] a);
    if (a == 14'h2400) return 8'h3C;
    return a[7:0] ^ {a[13:8], 2'b10};
  endfunction

  // ACID external RAM: q registered one cycle after the read strobe
  logic [7:0] acid_mem [16384];
  logic       acid_init = 1'b0;
  logic [7:0] acid_q;
  assign asic_ram_q = acid_q;
  always @(posedge clk_sys) begin
    if (!acid_init) begin
      for (int i = 0; i < 16384; i++) acid_mem[i] <= pat(14'(i));
      acid_init <= 1'b1;
    end else begin
      if (asic_ram_wr) acid_mem[asic_ram_addr] <= asic_ram_din;
      if (asic_ram_rd) acid_q <= acid_mem[asic_ram_addr];
    end
  end

  // Model: one pending transaction with the cycle it was accepted in
  logic [7:0]  exp_mem [16384];
  logic [4:0]  m_rmr2;
  int          m_op;      // 0 none, 1 write, 2 read
  int          m_start, m_vcyc, cyc;
  logic [13:0] m_addr;
  logic [7:0]  m_din, m_rdata;
  logic        p_io, p_rd, p_wr;

  task automatic m_reset();
    m_rmr2 = 5'd0; m_op = 0; m_start = 0; m_vcyc = -1;
    m_addr = 14'd0; m_din = 8'd0; m_rdata = 8'hFF;
    p_io = 1'b0; p_rd = 1'b0; p_wr = 1'b0;
  endtask

  initial begin
    logic idle_before, pe, in_win;
    cyc = 0;
    for (int i = 0; i < 16384; i++) exp_mem[i] = pat(14'(i));
    m_reset();
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) begin
        m_reset();
      end else begin
        cyc++;
        idle_before = (m_op == 0);
        pe     = plus_mode && asic_unlocked && (m_rmr2[4:3] == 2'b11);
        in_win = (cpu_addr[15:14] == 2'b01);
        if (m_op != 0) begin
          if (!plus_mode) m_op = 0;
          else if (m_op == 1) begin
            exp_mem[m_addr] = m_din;
            m_op = 0;
          end else if (cyc == m_start + 2) begin
            m_rdata = exp_mem[m_addr];
            m_vcyc  = cyc;
            m_op    = 0;
          end
        end
        if (!plus_mode) m_rmr2 = 5'd0;
        else if (cpu_io_wr && !p_io && in_win && cpu_dout[7:5] == 3'b101 && asic_unlocked)
          m_rmr2 = cpu_dout[4:0];
        if (idle_before && pe && in_win) begin
          if (cpu_mem_wr && !p_wr) begin
            m_op = 1; m_start = cyc; m_addr = cpu_addr[13:0];
            m_din = (cpu_addr[13:0] <= 14'h0FFF) ? {4'h0, cpu_dout[3:0]} : cpu_dout;
          end else if (cpu_mem_rd && !p_rd) begin
            m_op = 2; m_start = cyc; m_addr = cpu_addr[13:0];
          end
        end
        p_io = cpu_io_wr; p_rd = cpu_mem_rd; p_wr = cpu_mem_wr;
      end
    end
  end

  int n_vec = 0, n_fail = 0, rd_cnt = 0, wr_cnt = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic exp_pe;
    exp_pe = plus_mode && asic_unlocked && (m_rmr2[4:3] == 2'b11);
    if (asic_ram_rd === 1'b1) rd_cnt++;
    if (asic_ram_wr === 1'b1) wr_cnt++;
    cmp("rmr2", rmr2, m_rmr2);
    cmp("lower_rom_sel", lower_rom_sel, m_rmr2[4:3]);
    cmp("cart_bank", cart_bank, m_rmr2[2:0]);
    cmp("asic_page_en", asic_page_en, exp_pe);
    cmp("asic_sel", asic_sel, exp_pe && cpu_addr[15:14] == 2'b01 && (cpu_mem_rd || cpu_mem_wr));
    cmp("busy", busy, m_op != 0);
    cmp("asic_ram_wr", asic_ram_wr, m_op == 1 && plus_mode);
    cmp("asic_ram_rd", asic_ram_rd, m_op == 2 && cyc == m_start && plus_mode);
    cmp("asic_ram_addr", asic_ram_addr, m_addr);
    cmp("asic_ram_din", asic_ram_din, m_din);
    cmp("cpu_rdata", cpu_rdata, m_rdata);
    cmp("cpu_rdata_valid", cpu_rdata_valid, cyc == m_vcyc);
  endtask

  task automatic sample(); @(negedge clk_sys); compare_all(); endtask
  task automatic adv();    @(posedge clk_sys); #1;            endtask
  task automatic tick();   sample(); adv();                    endtask
  task automatic idle(input int n); repeat (n) tick(); endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    $display("io_wr   %h <= %h", a, d);
    cpu_addr = a; cpu_dout = d; cpu_io_wr = 1'b1;
    idle(3);
    cpu_io_wr = 1'b0;
    idle(1);
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    $display("mem_wr  %h <= %h hold %0d", a, d, hold);
    cpu_addr = a; cpu_dout = d; cpu_mem_wr = 1'b1;
    idle(hold);
    cpu_mem_wr = 1'b0;
    idle(2);
  endtask

  task automatic mem_read(input logic [15:0] a, input int hold);
    $display("mem_rd  %h hold %0d", a, hold);
    cpu_addr = a; cpu_mem_rd = 1'b1;
    idle(hold);
    cpu_mem_rd = 1'b0;
    idle(3);
  endtask

  initial begin
    int wc, rc;
    reset_n = 1'b0; plus_mode = 1'b1; asic_unlocked = 1'b0;
    cpu_addr = 16'h0; cpu_dout = 8'h0;
    cpu_io_wr = 1'b0; cpu_mem_rd = 1'b0; cpu_mem_wr = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    sample();
    cmp("rst_rmr2", rmr2, 5'h00);
    cmp("rst_rdata", cpu_rdata, 8'hFF);
    cmp("rst_busy", busy, 1'b0);
    adv();
    reset_n = 1'b1;
    idle(2);

    // RMR2 gating
    io_write(16'h7F00, 8'hB8);
    cmp("locked_rmr2", rmr2, 5'h00);
    asic_unlocked = 1'b1;
    $display("io_wr   7f00 <= b8 (unlocked)");
    cpu_addr = 16'h7F00; cpu_dout = 8'hB8; cpu_io_wr = 1'b1;
    tick();
    sample();
    cmp("rmr2_set", rmr2, 5'h18);
    cmp("page_en_set", asic_page_en, 1'b1);
    adv();
    tick();
    cpu_io_wr = 1'b0;
    tick();
    io_write(16'h7F00, 8'h98);
    cmp("rmr2_keep", rmr2, 5'h18);

    // Page disabled: no strobes, rdata untouched
    io_write(16'h7F00, 8'hB0);
    cmp("rmr2_10", rmr2, 5'h10);
    rc = rd_cnt;
    cpu_addr = 16'h6400; cpu_mem_rd = 1'b1;
    $display("mem_rd  6400 (page disabled)");
    sample();
    cmp("dis_sel", asic_sel, 1'b0);
    adv();
    idle(3);
    cpu_mem_rd = 1'b0;
    idle(2);
    cmp("dis_rd_cnt", rd_cnt - rc, 0);
    cmp("dis_rdata", cpu_rdata, 8'hFF);
    io_write(16'h7F00, 8'hB8);

    // Write path with held strobe and nibble boundary
    wc = wr_cnt;
    mem_write(16'h6800, 8'hA5, 4);
    cmp("wr_once", wr_cnt - wc, 1);
    cmp("wr_addr", asic_ram_addr, 14'h2800);
    cmp("wr_din", asic_ram_din, 8'hA5);
    mem_write(16'h4010, 8'hA5, 4);
    cmp("nib_din", asic_ram_din, 8'h05);
    mem_write(16'h4FFF, 8'hC3, 1);
    cmp("nib_end_din", asic_ram_din, 8'h03);
    mem_write(16'h5000, 8'hC3, 1);
    cmp("full_din", asic_ram_din, 8'hC3);

    // Read path latency
    $display("mem_rd  6400 (timed)");
    cpu_addr = 16'h6400; cpu_mem_rd = 1'b1;
    tick();
    sample();
    cmp("rd_strobe", asic_ram_rd, 1'b1);
    cmp("rd_sel", asic_sel, 1'b1);
    adv();
    tick();
    sample();
    cmp("rd_valid", cpu_rdata_valid, 1'b1);
    cmp("rd_data", cpu_rdata, 8'h3C);
    adv();
    cpu_mem_rd = 1'b0;
    idle(2);
    mem_read(16'h6800, 2);
    cmp("rb_6800", cpu_rdata, 8'hA5);
    mem_read(16'h4010, 1);
    cmp("rb_4010", cpu_rdata, 8'h05);

    // Simultaneous edges: write wins
    wc = wr_cnt; rc = rd_cnt;
    $display("mem_rd+wr 5000 <= 77");
    cpu_addr = 16'h5000; cpu_dout = 8'h77; cpu_mem_rd = 1'b1; cpu_mem_wr = 1'b1;
    idle(2);
    cpu_mem_rd = 1'b0; cpu_mem_wr = 1'b0;
    idle(3);
    cmp("sim_wr", wr_cnt - wc, 1);
    cmp("sim_rd", rd_cnt - rc, 0);

    // Edge during RD_WAIT is dropped
    wc = wr_cnt; rc = rd_cnt;
    $display("mem_rd  6400 then mem_wr 5000 while busy");
    cpu_addr = 16'h6400; cpu_mem_rd = 1'b1;
    tick();
    cpu_mem_rd = 1'b0;
    tick();
    cpu_addr = 16'h5000; cpu_dout = 8'h11; cpu_mem_wr = 1'b1;
    idle(2);
    cpu_mem_wr = 1'b0;
    idle(2);
    cmp("busy_wr_drop", wr_cnt - wc, 0);
    cmp("busy_rd_one", rd_cnt - rc, 1);

    // plus_mode falls during RD_ISSUE
    rc = rd_cnt;
    $display("mem_rd  6400 with plus_mode drop");
    cpu_addr = 16'h6400; cpu_mem_rd = 1'b1;
    tick();
    cpu_mem_rd = 1'b0; plus_mode = 1'b0;
    idle(3);
    cmp("pm_rmr2", rmr2, 5'h00);
    cmp("pm_rd", rd_cnt - rc, 0);
    cmp("pm_busy", busy, 1'b0);
    plus_mode = 1'b1;
    io_write(16'h7F00, 8'hB8);

    // Asynchronous reset in RD_WAIT
    $display("mem_rd  6400 with reset in RD_WAIT");
    cpu_addr = 16'h6400; cpu_mem_rd = 1'b1;
    tick();
    cpu_mem_rd = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    #1;
    cmp("ar_busy", busy, 1'b0);
    cmp("ar_rdata", cpu_rdata, 8'hFF);
    cmp("ar_valid", cpu_rdata_valid, 1'b0);
    cmp("ar_rmr2", rmr2, 5'h00);
    cmp("ar_page_en", asic_page_en, 1'b0);
    cmp("ar_addr", asic_ram_addr, 14'h0000);
    cmp("ar_din", asic_ram_din, 8'h00);
    cmp("ar_rd", asic_ram_rd, 1'b0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    io_write(16'h7F00, 8'hB8);
    mem_read(16'h6400, 2);
    cmp("post_rst_rdata", cpu_rdata, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
